// File: rtl/router_sync_param_if.sv
// Bundle between the router FSM/register stage, the output FIFOs and the sync block.
// The master side drives the request and status inputs. The slave side is the synchroniser.
interface router_sync_param_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] data_in;
  logic              detect_add;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic              timeout_clr;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic [NUM_CH-1:0] timeout_sts;
  logic              addr_err;

  modport master (
    output data_in, detect_add, write_enb_reg, read_enb, empty, full, timeout_clr,
    input  write_enb, fifo_full, vld_out, soft_reset, timeout_sts, addr_err
  );
  modport slave (
    input  data_in, detect_add, write_enb_reg, read_enb, empty, full, timeout_clr,
    output write_enb, fifo_full, vld_out, soft_reset, timeout_sts, addr_err
  );
endinterface

// File: rtl/router_sync_param.sv
// Router synchroniser: captures the address, steers the FIFO write enable and muxes the full flag.
// Each channel also has a read-timeout watchdog that pulses soft_reset.
module router_sync_param_wdog #(
  parameter int TIMEOUT    = 30,
  parameter int SRST_PULSE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd,
  input  logic clr,
  output logic soft_reset,
  output logic sts
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(SRST_PULSE + 1);

  logic [CW-1:0] cnt;
  logic [PW-1:0] tmr;
  logic          fire;

  assign fire = (tmr == '0) && vld && !rd && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      tmr        <= '0;
      soft_reset <= 1'b0;
      sts        <= 1'b0;
    end else begin
      if (tmr != '0) begin
        // The counter is frozen during the pulse. The pulse drops on the edge that drains the timer.
        tmr        <= tmr - PW'(1);
        soft_reset <= (tmr != PW'(1));
        cnt        <= '0;
      end else if (!vld || rd) begin
        cnt <= '0;
      end else if (fire) begin
        cnt        <= '0;
        tmr        <= PW'(SRST_PULSE);
        soft_reset <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (fire)     sts <= 1'b1;
      else if (clr) sts <= 1'b0;
    end
  end
endmodule

module router_sync_param #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 2,
  parameter int TIMEOUT    = 30,
  parameter int SRST_PULSE = 1
) (
  input logic clk,
  input logic rst,
  router_sync_param_if.slave bus
);
  logic [ADDR_W-1:0] fifo_addr;
  logic              addr_err;
  logic [NUM_CH-1:0] write_enb, we_nxt;
  logic              fifo_full;
  logic [NUM_CH-1:0] srst, sts;

  // Compare against each existing channel so that unused address codes decode to nothing.
  always_comb begin
    we_nxt    = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (fifo_addr == ADDR_W'(i)) begin
        we_nxt[i] = bus.write_enb_reg;
        fifo_full = bus.full[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_addr <= '0;
      addr_err  <= 1'b0;
      write_enb <= '0;
    end else begin
      if (bus.detect_add) begin
        fifo_addr <= bus.data_in;
        addr_err  <= (32'(bus.data_in) >= 32'(NUM_CH));
      end
      write_enb <= we_nxt;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    router_sync_param_wdog #(.TIMEOUT(TIMEOUT), .SRST_PULSE(SRST_PULSE)) u_wdog (
      .clk        (clk),
      .rst        (rst),
      .vld        (!bus.empty[i]),
      .rd         (bus.read_enb[i]),
      .clr        (bus.timeout_clr),
      .soft_reset (srst[i]),
      .sts        (sts[i])
    );
  end

  assign bus.write_enb   = write_enb;
  assign bus.fifo_full   = fifo_full;
  assign bus.vld_out     = ~bus.empty;
  assign bus.soft_reset  = srst;
  assign bus.timeout_sts = sts;
  assign bus.addr_err    = addr_err;
endmodule

// File: tb/tb_router_sync_param.sv
// Directed bench: a vector table for address, steering and reset behaviour.
// Hand sequences cover the watchdog timing on the default and swept configurations.
module tb_router_sync_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  router_sync_param_if #(.NUM_CH(3), .ADDR_W(2)) ifa ();
  router_sync_param_if #(.NUM_CH(4), .ADDR_W(2)) ifb ();

  router_sync_param dut_a (.clk(clk), .rst(rst), .bus(ifa));
  router_sync_param #(.NUM_CH(4), .ADDR_W(2), .TIMEOUT(5), .SRST_PULSE(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       r;
    logic       det;
    logic [1:0] d;
    logic       wer;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] we;
    logic       ff;
    logic       ae;
    logic [2:0] vld;
  } vec_t;

  vec_t tv[14];

  initial begin
    ifa.data_in = '0; ifa.detect_add = 0; ifa.write_enb_reg = 0; ifa.read_enb = '0;
    ifa.empty = '1; ifa.full = '0; ifa.timeout_clr = 0;
    ifb.data_in = '0; ifb.detect_add = 0; ifb.write_enb_reg = 0; ifb.read_enb = '0;
    ifb.empty = '1; ifb.full = '0; ifb.timeout_clr = 0;

    //          r  det d     wer full    empty   we      ff ae vld
    tv[0]  = '{0, 1, 2'd2, 1, 3'b111, 3'b010, 3'b000, 1, 0, 3'b101};
    tv[1]  = '{0, 1, 2'd3, 1, 3'b000, 3'b101, 3'b000, 0, 0, 3'b010};
    tv[2]  = '{1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000, 0, 0, 3'b000};
    tv[3]  = '{1, 1, 2'd2, 0, 3'b000, 3'b111, 3'b000, 0, 0, 3'b000};
    tv[4]  = '{1, 0, 2'd0, 1, 3'b100, 3'b111, 3'b100, 1, 0, 3'b000};
    tv[5]  = '{1, 0, 2'd0, 1, 3'b000, 3'b110, 3'b100, 0, 0, 3'b001};
    tv[6]  = '{1, 0, 2'd0, 1, 3'b100, 3'b111, 3'b100, 1, 0, 3'b000};
    tv[7]  = '{1, 0, 2'd0, 0, 3'b100, 3'b111, 3'b000, 1, 0, 3'b000};
    tv[8]  = '{1, 1, 2'd3, 0, 3'b111, 3'b111, 3'b000, 0, 1, 3'b000};
    tv[9]  = '{1, 0, 2'd0, 1, 3'b111, 3'b111, 3'b000, 0, 1, 3'b000};
    tv[10] = '{1, 1, 2'd0, 0, 3'b001, 3'b111, 3'b000, 1, 0, 3'b000};
    tv[11] = '{1, 1, 2'd1, 1, 3'b010, 3'b111, 3'b001, 1, 0, 3'b000};
    tv[12] = '{1, 0, 2'd0, 1, 3'b000, 3'b011, 3'b010, 0, 0, 3'b100};
    tv[13] = '{1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000, 0, 0, 3'b000};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = tv[i].r;
      ifa.detect_add = tv[i].det; ifa.data_in = tv[i].d; ifa.write_enb_reg = tv[i].wer;
      ifa.full = tv[i].full; ifa.empty = tv[i].empty;
      @(posedge clk); #1;
      chk($sformatf("v%0d write_enb", i), 32'(ifa.write_enb), 32'(tv[i].we));
      chk($sformatf("v%0d fifo_full", i), 32'(ifa.fifo_full), 32'(tv[i].ff));
      chk($sformatf("v%0d addr_err", i), 32'(ifa.addr_err), 32'(tv[i].ae));
      chk($sformatf("v%0d vld_out", i), 32'(ifa.vld_out), 32'(tv[i].vld));
      chk($sformatf("v%0d soft_reset", i), 32'(ifa.soft_reset), 32'h0);
      chk($sformatf("v%0d timeout_sts", i), 32'(ifa.timeout_sts), 32'h0);
    end
    ifa.detect_add = 0; ifa.write_enb_reg = 0;

    // Channel 1 is valid and unread from cycle 0. Pulses are expected at edges 30 and 61.
    for (int k = 1; k <= 61; k++) begin
      @(negedge clk);
      ifa.empty = 3'b101; ifa.read_enb = '0;
      @(posedge clk); #1;
      chk($sformatf("to k%0d soft_reset", k), 32'(ifa.soft_reset),
          (k == 30 || k == 61) ? 32'h2 : 32'h0);
      chk($sformatf("to k%0d timeout_sts", k), 32'(ifa.timeout_sts), (k >= 30) ? 32'h2 : 32'h0);
    end
    @(negedge clk);
    ifa.empty = 3'b111; ifa.timeout_clr = 1;
    @(posedge clk); #1;
    chk("clr timeout_sts", 32'(ifa.timeout_sts), 32'h0);
    chk("clr soft_reset", 32'(ifa.soft_reset), 32'h0);
    ifa.timeout_clr = 0;

    // A single read at cycle 29 restarts the count, so the next pulse lands at edge 60.
    for (int k = 1; k <= 61; k++) begin
      @(negedge clk);
      ifa.empty = 3'b101; ifa.read_enb = (k == 30) ? 3'b010 : 3'b000;
      @(posedge clk); #1;
      chk($sformatf("rescue k%0d soft_reset", k), 32'(ifa.soft_reset), (k == 60) ? 32'h2 : 32'h0);
      chk($sformatf("rescue k%0d timeout_sts", k), 32'(ifa.timeout_sts),
          (k >= 60) ? 32'h2 : 32'h0);
    end
    @(negedge clk);
    ifa.empty = 3'b111; ifa.read_enb = '0;

    // Swept configuration uses TIMEOUT=5 and a 3-cycle pulse. The clear at edge 13 collides with a new set.
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      ifb.empty = 4'b0111;
      ifb.timeout_clr = (k == 10 || k == 13);
      @(posedge clk); #1;
      chk($sformatf("sweep k%0d soft_reset", k), 32'(ifb.soft_reset),
          ((k >= 5 && k <= 7) || k >= 13) ? 32'h8 : 32'h0);
      chk($sformatf("sweep k%0d timeout_sts", k), 32'(ifb.timeout_sts),
          ((k >= 5 && k <= 9) || k >= 13) ? 32'h8 : 32'h0);
    end
    ifb.timeout_clr = 0;

    // A reset in the middle of a pulse cuts the pulse short.
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("midpulse rst soft_reset", 32'(ifb.soft_reset), 32'h0);
    chk("midpulse rst timeout_sts", 32'(ifb.timeout_sts), 32'h0);
    @(negedge clk);
    rst = 1;
    ifb.detect_add = 1; ifb.data_in = 2'd3; ifb.full = 4'b1000;
    @(posedge clk); #1;
    chk("b addr3 addr_err", 32'(ifb.addr_err), 32'h0);
    chk("b addr3 fifo_full", 32'(ifb.fifo_full), 32'h1);
    chk("b after rst soft_reset", 32'(ifb.soft_reset), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
